// File: rtl/floating_point_divider.sv
`default_nettype none
// ============================================================================
// Module      : floating_point_divider
// Description : Iterative IEEE-754 single-precision divider, quotient = x / y.
//               Restoring mantissa division, one quotient bit per clock, with
//               a start/busy/done handshake. Normal operands only; exponent
//               0/255 operands with nonzero mantissa are treated as normals.
// Ports       : clk         - clock, all state on rising edge
//               rst         - synchronous active-high reset (aborts any op)
//               start       - request, sampled only while idle
//               x, y        - dividend / divisor (IEEE-754 single)
//               busy        - operation in flight (CALC and NORM cycles)
//               done        - one-cycle pulse, quotient and flags valid
//               quotient    - result, held until rewritten
//               overflow    - result exponent >= 255, quotient = signed inf
//               underflow   - result exponent <= 0, quotient = signed zero
//               div_by_zero - divisor is zero
// Revision    : 1.0 - initial release
// ============================================================================
module floating_point_divider #(
    parameter int ROUND = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero
);

    localparam int c_ITER = 25 + ROUND;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_CALC = 2'd1;
    localparam logic [1:0] c_S_NORM = 2'd2;
    localparam logic [1:0] c_S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [24:0]       r_rem;
    logic [23:0]       r_div;
    logic [c_ITER-1:0] r_q;
    logic [4:0]        r_cnt;
    logic [31:0]       r_quot;
    logic              r_ovf;
    logic              r_unf;
    logic              r_dz;

    // ------------------------------------------------------------------
    // Operand decode
    // ------------------------------------------------------------------
    logic       w_x_zero;
    logic       w_y_zero;
    logic       w_sign;
    logic [9:0] w_e_start;
    logic       w_accept;

    assign w_x_zero  = (x[30:0] == 31'd0);
    assign w_y_zero  = (y[30:0] == 31'd0);
    assign w_sign    = x[31] ^ y[31];
    assign w_e_start = {2'b00, x[30:23]} - {2'b00, y[30:23]} + 10'd127;
    assign w_accept  = (r_state == c_S_IDLE) && start;

    // ------------------------------------------------------------------
    // One restoring step. The remainder is always below twice the divisor,
    // so after a successful subtract the difference fits in 24 bits and
    // the low 24 bits of the subtraction are exact.
    // ------------------------------------------------------------------
    logic        w_ge;
    logic [23:0] w_sub;
    logic [24:0] w_rem_nxt;

    assign w_ge      = (r_rem >= {1'b0, r_div});
    assign w_sub     = r_rem[23:0] - r_div;
    assign w_rem_nxt = w_ge ? {w_sub, 1'b0} : {r_rem[23:0], 1'b0};

    // ------------------------------------------------------------------
    // Normalisation and rounding. The raw ratio lies in [0.5, 2), so at
    // most one position of left shift is needed.
    // ------------------------------------------------------------------
    logic              w_msb;
    logic [22:0]       w_mant_t;
    logic signed [9:0] w_exp_t;
    logic              w_guard;
    logic [23:0]       w_mant_sum;
    logic              w_carry;
    logic [22:0]       w_mant;
    logic signed [9:0] w_exp;
    logic              w_ovf;
    logic              w_unf;

    assign w_msb    = r_q[c_ITER-1];
    assign w_mant_t = w_msb ? r_q[c_ITER-2 -: 23] : r_q[c_ITER-3 -: 23];
    assign w_exp_t  = w_msb ? r_exp : (r_exp - 10'sd1);

    generate
        if (ROUND != 0) begin : g_round
            assign w_guard = w_msb ? r_q[c_ITER-25] : r_q[c_ITER-26];
        end else begin : g_trunc
            assign w_guard = 1'b0;
        end
    endgenerate

    assign w_mant_sum = {1'b0, w_mant_t} + {23'd0, w_guard};
    assign w_carry    = w_mant_sum[23];
    assign w_mant     = w_carry ? 23'd0 : w_mant_sum[22:0];
    assign w_exp      = w_carry ? (w_exp_t + 10'sd1) : w_exp_t;
    assign w_ovf      = (w_exp >= 10'sd255);
    assign w_unf      = (w_exp <= 10'sd0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_x_zero || w_y_zero) ? c_S_DONE : c_S_CALC;
                end
            end
            c_S_CALC: begin
                if (r_cnt == 5'd0) begin
                    w_state_nxt = c_S_NORM;
                end
            end
            c_S_NORM: w_state_nxt = c_S_DONE;
            c_S_DONE: w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_S_CALC: busy = 1'b1;
            c_S_NORM: busy = 1'b1;
            c_S_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_exp  <= 10'sd0;
            r_rem  <= 25'd0;
            r_div  <= 24'd0;
            r_q    <= '0;
            r_cnt  <= 5'd0;
            r_quot <= 32'd0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign <= w_sign;
                r_exp  <= w_e_start;
                r_rem  <= {2'b01, x[22:0]};
                r_div  <= {1'b1, y[22:0]};
                r_q    <= '0;
                r_cnt  <= 5'(c_ITER - 1);
                r_ovf  <= 1'b0;
                r_unf  <= 1'b0;
                r_dz   <= 1'b0;
                // Zero operands are resolved here and skip the datapath
                if (w_x_zero && w_y_zero) begin
                    r_quot <= 32'h7FC0_0000;
                    r_dz   <= 1'b1;
                end else if (w_y_zero) begin
                    r_quot <= {w_sign, 8'hFF, 23'd0};
                    r_dz   <= 1'b1;
                end else if (w_x_zero) begin
                    r_quot <= {w_sign, 31'd0};
                end
            end else if (r_state == c_S_CALC) begin
                r_rem <= w_rem_nxt;
                r_q   <= {r_q[c_ITER-2:0], w_ge};
                r_cnt <= r_cnt - 5'd1;
            end else if (r_state == c_S_NORM) begin
                if (w_ovf) begin
                    r_ovf  <= 1'b1;
                    r_quot <= {r_sign, 8'hFF, 23'd0};
                end else if (w_unf) begin
                    r_unf  <= 1'b1;
                    r_quot <= {r_sign, 31'd0};
                end else begin
                    r_quot <= {r_sign, w_exp[7:0], w_mant};
                end
            end
        end
    end

    assign quotient    = r_quot;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;
    assign div_by_zero = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_floating_point_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_floating_point_divider
// Description : Directed bench for floating_point_divider. Two instances share
//               all inputs: one truncating (ROUND=0), one rounding (ROUND=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floating_point_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;

    logic        busy0, done0, ovf0, unf0, dz0;
    logic [31:0] quot0;
    logic        busy1, done1, ovf1, unf1, dz1;
    logic [31:0] quot1;

    int n_cmp;
    int n_err;

    logic [31:0] q0, q1;
    logic [2:0]  fl0, fl1;
    int          lat0, lat1, nd0, nd1;

    floating_point_divider #(.ROUND(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .busy(busy0), .done(done0), .quotient(quot0),
        .overflow(ovf0), .underflow(unf0), .div_by_zero(dz0)
    );

    floating_point_divider #(.ROUND(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .busy(busy1), .done(done1), .quotient(quot1),
        .overflow(ovf1), .underflow(unf1), .div_by_zero(dz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one start, then watch both instances for 32 edges. The sampling
    // edge counts as edge 1. Optionally pulse a second start at edge inj,
    // or assert rst during the cycle following edge rst_at.
    task automatic run_op(input logic [31:0] xv, input logic [31:0] yv,
                          input int inj, input int rst_at);
        @(negedge clk);
        x = xv;
        y = yv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nd0 = 0; nd1 = 0; lat0 = 0; lat1 = 0;
        q0 = 32'hDEAD_BEEF; q1 = 32'hDEAD_BEEF; fl0 = 3'b111; fl1 = 3'b111;
        for (int n = 1; n <= 32; n++) begin
            if (done0) begin
                nd0++;
                if (nd0 == 1) begin
                    lat0 = n; q0 = quot0; fl0 = {ovf0, unf0, dz0};
                end
            end
            if (done1) begin
                nd1++;
                if (nd1 == 1) begin
                    lat1 = n; q1 = quot1; fl1 = {ovf1, unf1, dz1};
                end
            end
            if (rst_at != 0 && n == rst_at + 1) begin
                chk("abort_busy0", {31'd0, busy0}, 32'd0);
                chk("abort_busy1", {31'd0, busy1}, 32'd0);
                chk("abort_quot0", quot0, 32'd0);
                rst = 1'b0;
            end
            if (inj != 0 && n == inj) begin
                x = 32'h3F80_0000;
                y = 32'h0000_0000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (rst_at != 0 && n == rst_at) rst = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_res(input string tag,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [2:0] ef, input int el0, input int el1);
        chk({tag, "_q0"}, q0, e0);
        chk({tag, "_q1"}, q1, e1);
        chk({tag, "_fl0"}, {29'd0, fl0}, {29'd0, ef});
        chk({tag, "_fl1"}, {29'd0, fl1}, {29'd0, ef});
        chk({tag, "_lat0"}, lat0, el0);
        chk({tag, "_lat1"}, lat1, el1);
        chk({tag, "_npulse0"}, nd0, 32'd1);
        chk({tag, "_npulse1"}, nd1, 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        x     = 32'd0;
        y     = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_quot0", quot0, 32'd0);
        chk("rst_quot1", quot1, 32'd0);
        chk("rst_ctl0", {28'd0, busy0, done0, ovf0, unf0}, 32'd0);
        chk("rst_ctl1", {28'd0, busy1, done1, ovf1, unf1}, 32'd0);
        chk("rst_dz", {30'd0, dz0, dz1}, 32'd0);

        // 6.0 / 2.0 = 3.0
        run_op(32'h40C0_0000, 32'h4000_0000, 0, 0);
        expect_res("six_by_two", 32'h4040_0000, 32'h4040_0000, 3'b000, 27, 28);

        // 1 / 3: truncation versus round-half-up
        run_op(32'h3F80_0000, 32'h4040_0000, 0, 0);
        expect_res("one_third", 32'h3EAA_AAAA, 32'h3EAA_AAAB, 3'b000, 27, 28);

        // -8.0 / 0.5 = -16.0
        run_op(32'hC100_0000, 32'h3F00_0000, 0, 0);
        expect_res("neg_eight", 32'hC180_0000, 32'hC180_0000, 3'b000, 27, 28);

        // Ratio 1 + 2^-24 (+tiny): guard bit set only in rounding instance
        run_op(32'h3FFF_FFFF, 32'h3FFF_FFFE, 0, 0);
        expect_res("guard_up", 32'h3F80_0000, 32'h3F80_0001, 3'b000, 27, 28);

        // Division by zero, both zero, zero dividend
        run_op(32'h3F80_0000, 32'h0000_0000, 0, 0);
        expect_res("div_zero", 32'h7F80_0000, 32'h7F80_0000, 3'b001, 1, 1);
        run_op(32'h0000_0000, 32'h8000_0000, 0, 0);
        expect_res("zero_zero", 32'h7FC0_0000, 32'h7FC0_0000, 3'b001, 1, 1);
        run_op(32'h8000_0000, 32'h4000_0000, 0, 0);
        expect_res("zero_num", 32'h8000_0000, 32'h8000_0000, 3'b000, 1, 1);

        // Overflow and underflow
        run_op(32'h7F00_0000, 32'h3E80_0000, 0, 0);
        expect_res("overflow", 32'h7F80_0000, 32'h7F80_0000, 3'b100, 27, 28);
        run_op(32'h0080_0000, 32'h4000_0000, 0, 0);
        expect_res("underflow", 32'h0000_0000, 32'h0000_0000, 3'b010, 27, 28);

        // Start pulsed mid-CALC (with a divide-by-zero operand pair) is ignored
        run_op(32'h40C0_0000, 32'h4000_0000, 5, 0);
        expect_res("mid_start", 32'h4040_0000, 32'h4040_0000, 3'b000, 27, 28);

        // Reset on the 10th CALC cycle aborts; done never fires
        run_op(32'h3F80_0000, 32'h4040_0000, 0, 10);
        chk("abort_npulse0", nd0, 32'd0);
        chk("abort_npulse1", nd1, 32'd0);

        // Fresh operation after the abort
        run_op(32'h3F80_0000, 32'h4040_0000, 0, 0);
        expect_res("after_abort", 32'h3EAA_AAAA, 32'h3EAA_AAAB, 3'b000, 27, 28);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
